// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore sequencer, ALU/immediate decoders, retired-instruction counter.
// Define MC_CTRL_BNE_EN to add bne; otherwise every 1100011 branch resolves as beq.
module mc_control_unit #(
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_ready;
  logic             w_retire;
  logic             w_taken;
  logic             w_pcupdate;
  logic             w_branch;
  logic             w_adrsrc;
  logic             w_memwrite;
  logic             w_irwrite;
  logic             w_regwrite;
  logic             w_illegal;
  logic [1:0]       w_resultsrc;
  logic [1:0]       w_alusrca;
  logic [1:0]       w_alusrcb;
  logic [1:0]       w_aluop;

  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (w_ready) w_next = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: w_next = MEMADR;
          7'b0110011:             w_next = EXECR;
          7'b0010011:             w_next = EXECI;
          7'b1101111:             w_next = JAL;
          7'b1100011:             w_next = BEQ;
          default:                w_next = TRAP;
        endcase
      end
      MEMADR:   w_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (w_ready) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (w_ready) w_next = FETCH;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      JAL:      w_next = ALUWB;
      BEQ:      w_next = FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  // JAL is not counted here; it retires on its ALUWB exit.
  assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BEQ) ||
                    ((r_state == MEMWRITE) && w_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_aluop     = 2'b00;
    case (r_state)
      FETCH: begin
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_irwrite   = w_ready;
        w_pcupdate  = w_ready;
      end
      DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
      end
      MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      MEMREAD:  w_adrsrc = 1'b1;
      MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECR: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b10;
      end
      EXECI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = 2'b10;
      end
      ALUWB:    w_regwrite = 1'b1;
      JAL: begin
        w_alusrca  = 2'b01;
        w_alusrcb  = 2'b10;
        w_pcupdate = 1'b1;
      end
      BEQ: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b01;
        w_branch  = 1'b1;
      end
      TRAP:     w_illegal = 1'b1;
      default:  w_illegal = 1'b0;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      default: w_taken = 1'b0;
    endcase
  end
`else
  assign w_taken = zero;
`endif

  always_comb begin
    ALUControl = 3'b000;
    case (w_aluop)
      2'b01:   ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // Write strobes are masked for the whole reset pulse so nothing commits mid-reset.
  assign PCWrite   = ~reset & (w_pcupdate | (w_branch & w_taken));
  assign IRWrite   = ~reset & w_irwrite;
  assign RegWrite  = ~reset & w_regwrite;
  assign MemWrite  = ~reset & w_memwrite;
  assign AdrSrc    = w_adrsrc;
  assign ResultSrc = w_resultsrc;
  assign ALUSrcA   = w_alusrca;
  assign ALUSrcB   = w_alusrcb;
  assign illegal   = w_illegal;
  assign instret   = r_instret;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; expected control words are hand-derived per state.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;
  logic [16:0] obs;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 0;

  mc_control_unit #(.CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,illegal}
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegWrite, ALUControl, illegal};

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0110011;
    #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_00_0_000_0) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", obs, 17'b0_0_0_0_10_00_10_00_0_000_0);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL reset_instret got %0d exp 0", instret);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_add();
    logic [16:0] exp_v [4];
    exp_v = '{17'b1_0_0_1_10_00_10_00_0_000_0, 17'b0_0_0_0_00_01_01_00_0_000_0,
              17'b0_0_0_0_00_10_00_00_0_000_0, 17'b0_0_0_0_00_00_00_00_1_000_0};
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL add_cyc%0d got %b exp %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL add_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops [7];
    logic [2:0] f3s [7];
    logic       f7s [7];
    logic [2:0] alu [7];
    ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000, 3'b100, 3'b111};
    f7s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    alu = '{3'b001, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b010};
    mem_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
      for (int c = 0; c < 4; c++) begin
        #1;
        if (c == 2) begin
          checks++;
          if (ALUControl !== alu[k]) begin
            errors++; $display("FAIL alu_dec%0d got %b exp %b", k, ALUControl, alu[k]);
          end
        end
        @(negedge clk);
      end
      exp_instret++;
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL alu_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp_v [7];
    logic        rdy [7];
    exp_v = '{17'b1_0_0_1_10_00_10_00_0_000_0, 17'b0_0_0_0_00_01_01_00_0_000_0,
              17'b0_0_0_0_00_10_01_00_0_000_0, 17'b0_1_0_0_00_00_00_00_0_000_0,
              17'b0_1_0_0_00_00_00_00_0_000_0, 17'b0_1_0_0_00_00_00_00_0_000_0,
              17'b0_0_0_0_01_00_00_00_1_000_0};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL lw_cyc%0d got %b exp %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 17'b1_0_0_1_10_00_10_00_0_000_0) begin
      errors++; $display("FAIL lw_back_to_fetch got %b exp %b", obs, 17'b1_0_0_1_10_00_10_00_0_000_0);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL lw_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_sw_wait();
    logic [16:0] exp_v [6];
    logic        rdy [6];
    exp_v = '{17'b0_0_0_0_10_00_10_01_0_000_0, 17'b1_0_0_1_10_00_10_01_0_000_0,
              17'b0_0_0_0_00_01_01_01_0_000_0, 17'b0_0_0_0_00_10_01_01_0_000_0,
              17'b0_1_1_0_00_00_00_01_0_000_0, 17'b0_1_1_0_00_00_00_01_0_000_0};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL sw_cyc%0d got %b exp %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL sw_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_jal();
    logic [16:0] exp_v [4];
    exp_v = '{17'b1_0_0_1_10_00_10_11_0_000_0, 17'b0_0_0_0_00_01_01_11_0_000_0,
              17'b1_0_0_0_00_01_10_11_0_000_0, 17'b0_0_0_0_00_00_00_11_1_000_0};
    op = 7'b1101111; funct3 = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL jal_cyc%0d got %b exp %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL jal_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp_v [3];
    op = 7'b1100011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      exp_v = '{17'b1_0_0_1_10_00_10_10_0_000_0, 17'b0_0_0_0_00_01_01_10_0_000_0,
                {z[0], 16'b0_0_0_00_10_00_10_0_001_0}};
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (obs !== exp_v[i]) begin
          errors++; $display("FAIL beq_z%0d_cyc%0d got %b exp %b", z, i, obs, exp_v[i]);
        end
        @(negedge clk);
      end
      exp_instret++;
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL beq_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_bne();
    logic [2:0] f3s [4];
    logic       zs [4];
    logic       pcw [4];
    f3s = '{3'b001, 3'b001, 3'b100, 3'b000};
    zs  = '{1'b0, 1'b1, 1'b1, 1'b1};
`ifdef MC_CTRL_BNE_EN
    pcw = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    pcw = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif
    op = 7'b1100011; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3s[k]; zero = zs[k];
      for (int c = 0; c < 3; c++) begin
        #1;
        if (c == 2) begin
          checks++;
          if (obs !== {pcw[k], 16'b0_0_0_00_10_00_10_0_001_0}) begin
            errors++; $display("FAIL bne_case%0d got %b exp %b", k, obs,
                               {pcw[k], 16'b0_0_0_00_10_00_10_0_001_0});
          end
        end
        @(negedge clk);
      end
      exp_instret++;
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL bne_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_write();
    op = 7'b0100011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++; $display("FAIL midwr_memwrite_before got %b exp 1", MemWrite);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_01_0_000_0) begin
      errors++; $display("FAIL midwr_reset_outputs got %b exp %b", obs, 17'b0_0_0_0_10_00_10_01_0_000_0);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL midwr_instret got %0d exp 0", instret);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_01_0_000_0) begin
      errors++; $display("FAIL midwr_held_reset got %b exp %b", obs, 17'b0_0_0_0_10_00_10_01_0_000_0);
    end
    reset = 1'b0;
    exp_instret = 0;
    #1;
    checks++;
    if (obs !== 17'b1_0_0_1_10_00_10_01_0_000_0) begin
      errors++; $display("FAIL midwr_release got %b exp %b", obs, 17'b1_0_0_1_10_00_10_01_0_000_0);
    end
  endtask

  task automatic test_trap();
    op = 7'b1110011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; zero = i[1];
      #1;
      checks++;
      if (obs !== 17'b0_0_0_0_00_00_00_00_0_000_1) begin
        errors++; $display("FAIL trap_cyc%0d got %b exp %b", i, obs, 17'b0_0_0_0_00_00_00_00_0_000_1);
      end
      @(negedge clk);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL trap_instret got %0d exp %0d", instret, exp_instret);
    end
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL trap_exit_illegal got %b exp 0", illegal);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_instret = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_alu_decode();
    test_lw_wait();
    test_sw_wait();
    test_jal();
    test_beq();
    test_bne();
    test_reset_mid_write();
    test_add();
    test_trap();
    test_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
